regfile_clr_2r1w: RTL

//  Parametrised 2-read/1-write register file for the datapath, replacing the fixed 16x8 file.

---
 rtl/regfile_clr_2r1w.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_clr_2r1w.sv
// 2-read/1-write register file with registered read ports, optional write-to-read
// bypass, R0 hardwired to zero, and a sequential bulk-clear engine.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   wr_en/addr/data      write port; ignored for R0; dropped while clear engine active
//   rd_addr_a/b          read addresses
//   rd_data_a/b          read data, valid one cycle after the address
//   clr_req              start bulk clear of R1..R(DEPTH-1) (sampled in idle only)
//   clr_busy             high while registers are being cleared
//   clr_done             one-cycle pulse when the clear completes
//   wr_drop              one-cycle pulse: a write arrived while the engine was active
module regfile_clr_2r1w #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_drop
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_acc;
  logic [DATA_W-1:0] rd_a_d;
  logic [DATA_W-1:0] rd_b_d;

  // Read-port next values. Priority: R0 zero, then forwarded write, then the
  // register being cleared this edge (so a read of clr_idx sees 0), then storage.
  always_comb begin
    wr_acc = wr_en && (state_q == StIdle) && (wr_addr != '0);

    rd_a_d = mem_q[rd_addr_a];
    if (rd_addr_a == '0) begin
      rd_a_d = '0;
    end else if (BYPASS && wr_acc && (wr_addr == rd_addr_a)) begin
      rd_a_d = wr_data;
    end else if ((state_q == StClear) && (clr_idx_q == rd_addr_a)) begin
      rd_a_d = '0;
    end

    rd_b_d = mem_q[rd_addr_b];
    if (rd_addr_b == '0) begin
      rd_b_d = '0;
    end else if (BYPASS && wr_acc && (wr_addr == rd_addr_b)) begin
      rd_b_d = wr_data;
    end else if ((state_q == StClear) && (clr_idx_q == rd_addr_b)) begin
      rd_b_d = '0;
    end
  end

  // Storage. Writes and clearing are mutually exclusive (writes only in idle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        mem_q[wr_addr] <= wr_data;
      end
      if (state_q == StClear) begin
        mem_q[clr_idx_q] <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= rd_a_d;
      rd_data_b <= rd_b_d;
    end
  end

  // Clear engine with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      clr_idx_q <= FIRST_IDX;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
      wr_drop   <= 1'b0;
    end else begin
      wr_drop  <= wr_en && (state_q != StIdle);
      clr_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (clr_req) begin
            state_q   <= StClear;
            clr_idx_q <= FIRST_IDX;
            clr_busy  <= 1'b1;
          end
        end
        StClear: begin
          // Stop on the last index rather than wrapping the counter into R0.
          if (clr_idx_q == LAST_IDX) begin
            state_q  <= StDone;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + FIRST_IDX;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q  <= StIdle;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
